// File: rtl/keypad_ctrl_pkg.sv
// Shared definitions for the keypad entry controller: key codes, ALU opcodes,
// FSM state encoding and small key classification helpers.
package keypad_ctrl_pkg;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_MUL = 4'hC;
    localparam logic [3:0] KEY_EQ  = 4'hD;
    localparam logic [3:0] KEY_CLR = 4'hE;
    localparam logic [3:0] KEY_BSP = 4'hF;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_EQ  = 2'b11;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        DEBOUNCE     = 3'd1,
        ACCEPT       = 3'd2,
        ISSUE        = 3'd3,
        WAIT_RELEASE = 3'd4
    } state_t;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

    function automatic logic [1:0] key_to_op(input logic [3:0] k);
        case (k)
            KEY_ADD: return OP_ADD;
            KEY_SUB: return OP_SUB;
            KEY_MUL: return OP_MUL;
            KEY_EQ:  return OP_EQ;
            default: return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/key_stable_counter.sv
// Saturating up-counter used to measure how long a key (or its release) has
// been stable. done is high while the count sits at HOLD_CYCLES-1.
module key_stable_counter #(
    parameter int unsigned HOLD_CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic done
);
    localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign done = (cnt_q == CW'(HOLD_CYCLES - 1));

    // Next count: clear wins, otherwise count up and hold at the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !done) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: debounces key presses, builds a BCD operand from
// digit keys, handles clear/backspace locally and offers operand+opcode
// commands to the ALU over valid/ready.
// Optional feature macro: KEYPAD_AUTOREPEAT_EN (auto-repeat of held digit and
// backspace keys every REPEAT_CYCLES cycles).
module keypad_entry_ctrl
    import keypad_ctrl_pkg::*;
#(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned HOLD_CYCLES   = 8,
    parameter int unsigned REPEAT_CYCLES = 250000
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [3:0]                   key_value,
    input  logic                         key_valid,
    output logic [4*DIGITS-1:0]          operand,
    output logic [$clog2(DIGITS+1)-1:0]  digit_count,
    output logic [1:0]                   opcode,
    output logic                         cmd_valid,
    input  logic                         cmd_ready,
    output logic                         clear_pulse,
    output logic                         overflow
);
    localparam int unsigned OW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(DIGITS + 1);

    state_t        state_q, state_d;
    logic [3:0]    key_q, key_d;
    logic [OW-1:0] operand_q, operand_d;
    logic [CW-1:0] digit_count_q, digit_count_d;
    logic [1:0]    opcode_q, opcode_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic          clear_pulse_q, clear_pulse_d;
    logic          overflow_q, overflow_d;
    logic          do_edit;

    logic deb_clr, deb_en, deb_done;
    logic rel_clr, rel_en, rel_done;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
`else
    logic unused_rpt;
    assign unused_rpt = ^REPEAT_CYCLES;
`endif

    key_stable_counter #(.HOLD_CYCLES(HOLD_CYCLES)) u_debounce (
        .clk   (clk),
        .rst_n (reset_n),
        .clr   (deb_clr),
        .en    (deb_en),
        .done  (deb_done)
    );

    key_stable_counter #(.HOLD_CYCLES(HOLD_CYCLES)) u_release (
        .clk   (clk),
        .rst_n (reset_n),
        .clr   (rel_clr),
        .en    (rel_en),
        .done  (rel_done)
    );

    // Next-state and next-output logic; digit/backspace edits are shared
    // between a normal accept and an auto-repeat re-application.
    always_comb begin
        state_d       = state_q;
        key_d         = key_q;
        operand_d     = operand_q;
        digit_count_d = digit_count_q;
        opcode_d      = opcode_q;
        cmd_valid_d   = cmd_valid_q;
        clear_pulse_d = 1'b0;
        overflow_d    = overflow_q;
        do_edit       = 1'b0;
        deb_clr       = 1'b1;
        deb_en        = 1'b0;
        rel_clr       = 1'b1;
        rel_en        = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rpt_cnt_d     = '0;
`endif
        case (state_q)
            IDLE: begin
                if (key_valid) begin
                    key_d   = key_value;
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                deb_clr = 1'b0;
                if (!key_valid) begin
                    state_d = IDLE;
                end else if (key_value != key_q) begin
                    key_d   = key_value;
                    deb_clr = 1'b1;
                end else begin
                    deb_en = 1'b1;
                    if (deb_done) begin
                        state_d = ACCEPT;
                    end
                end
            end
            ACCEPT: begin
                if (is_digit(key_q) || key_q == KEY_BSP) begin
                    do_edit = 1'b1;
                    state_d = WAIT_RELEASE;
                end else if (key_q == KEY_CLR) begin
                    operand_d     = '0;
                    digit_count_d = '0;
                    overflow_d    = 1'b0;
                    clear_pulse_d = 1'b1;
                    state_d       = WAIT_RELEASE;
                end else begin
                    opcode_d    = key_to_op(key_q);
                    cmd_valid_d = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                // The command stays frozen until the ALU takes it.
                if (cmd_ready) begin
                    cmd_valid_d   = 1'b0;
                    operand_d     = '0;
                    digit_count_d = '0;
                    overflow_d    = 1'b0;
                    state_d       = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                rel_clr = key_valid;
                rel_en  = !key_valid;
                if (!key_valid && rel_done) begin
                    state_d = IDLE;
                end
`ifdef KEYPAD_AUTOREPEAT_EN
                if (key_valid && key_value == key_q &&
                    (is_digit(key_q) || key_q == KEY_BSP)) begin
                    if (rpt_cnt_q == RW'(REPEAT_CYCLES - 1)) begin
                        do_edit = 1'b1;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + RW'(1);
                    end
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (do_edit) begin
            if (is_digit(key_q)) begin
                if (digit_count_q < CW'(DIGITS)) begin
                    operand_d     = (operand_q << 4) | OW'(key_q);
                    digit_count_d = digit_count_q + CW'(1);
                end else begin
                    overflow_d = 1'b1;
                end
            end else if (digit_count_q != '0) begin
                operand_d     = operand_q >> 4;
                digit_count_d = digit_count_q - CW'(1);
            end
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            key_q         <= '0;
            operand_q     <= '0;
            digit_count_q <= '0;
            opcode_q      <= '0;
            cmd_valid_q   <= 1'b0;
            clear_pulse_q <= 1'b0;
            overflow_q    <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt_cnt_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            key_q         <= key_d;
            operand_q     <= operand_d;
            digit_count_q <= digit_count_d;
            opcode_q      <= opcode_d;
            cmd_valid_q   <= cmd_valid_d;
            clear_pulse_q <= clear_pulse_d;
            overflow_q    <= overflow_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt_cnt_q     <= rpt_cnt_d;
`endif
        end
    end

    assign operand     = operand_q;
    assign digit_count = digit_count_q;
    assign opcode      = opcode_q;
    assign cmd_valid   = cmd_valid_q;
    assign clear_pulse = clear_pulse_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Self-checking bench for keypad_entry_ctrl (DIGITS=4, HOLD_CYCLES=8).
// Builds with or without KEYPAD_AUTOREPEAT_EN.
module tb_keypad_entry_ctrl;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RPT = 50;
`else
    localparam int RPT = 250000;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  key_value;
    logic        key_valid;
    logic [15:0] operand;
    logic [2:0]  digit_count;
    logic [1:0]  opcode;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        clear_pulse;
    logic        overflow;

    keypad_entry_ctrl #(
        .DIGITS        (4),
        .HOLD_CYCLES   (8),
        .REPEAT_CYCLES (RPT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_value   (key_value),
        .key_valid   (key_valid),
        .operand     (operand),
        .digit_count (digit_count),
        .opcode      (opcode),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .clear_pulse (clear_pulse),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] op;
        logic [2:0]  cnt;
        logic        ovf;
    } exp_t;

    typedef struct packed {
        logic [15:0] op;
        logic [1:0]  code;
    } cmd_t;

    exp_t exp_q[$];
    cmd_t cmd_q[$];

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    int clr_pulses = 0;
    int clr_run = 0;
    int clr_max = 0;
    logic clr_prev = 1'b0;

    logic [15:0] m_op;
    logic [2:0]  m_cnt;
    logic        m_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model of the entry behaviour at the level of whole key presses.
    task automatic model_key(input logic [3:0] k);
        cmd_t c;
        if (k <= 4'd9) begin
            if (m_cnt < 3'd4) begin
                m_op  = {m_op[11:0], k};
                m_cnt = m_cnt + 3'd1;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (k == 4'hE) begin
            m_op = '0; m_cnt = '0; m_ovf = 1'b0;
        end else if (k == 4'hF) begin
            if (m_cnt != 3'd0) begin
                m_op  = m_op >> 4;
                m_cnt = m_cnt - 3'd1;
            end
        end else begin
            c.op   = m_op;
            c.code = 2'(k - 4'hA);
            cmd_q.push_back(c);
            m_op = '0; m_cnt = '0; m_ovf = 1'b0;
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.op = m_op; e.cnt = m_cnt; e.ovf = m_ovf;
        exp_q.push_back(e);
    endtask

    task automatic check_sb(input string tag);
        exp_t e;
        chk({tag, ".sb_pending"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, ".operand"}, operand, e.op);
            chk({tag, ".count"}, digit_count, e.cnt);
            chk({tag, ".overflow"}, overflow, e.ovf);
        end
    endtask

    // One press: drive from posedge+1, hold, release, then compare.
    task automatic press(input logic [3:0] k, input int hold, input string tag);
        key_value = k;
        key_valid = 1'b1;
        model_key(k);
        push_exp();
        repeat (hold) @(posedge clk);
        #1;
        key_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_sb(tag);
    endtask

    task automatic wait_cmd(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (cmd_valid === 1'b1) ok = 1'b1;
        end
    endtask

    // Handshake monitor: every accepted command is checked against the scoreboard.
    always @(negedge clk) begin : cmd_mon
        cmd_t c;
        if (reset_n && cmd_valid && cmd_ready) begin
            hs_cnt <= hs_cnt + 1;
            chk("cmd_expected", 32'(cmd_q.size() > 0), 32'd1);
            if (cmd_q.size() > 0) begin
                c = cmd_q.pop_front();
                chk("cmd_operand", operand, c.op);
                chk("cmd_opcode", opcode, c.code);
            end
        end
    end

    // Clear strobe monitor: counts pulses and their longest run.
    always @(negedge clk) begin
        if (clear_pulse === 1'b1) begin
            clr_run <= clr_run + 1;
            if (clr_run + 1 > clr_max) clr_max <= clr_run + 1;
            if (!clr_prev) clr_pulses <= clr_pulses + 1;
        end else begin
            clr_run <= 0;
        end
        clr_prev <= (clear_pulse === 1'b1);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int bad;
        int hs0;
        int clr0;

        reset_n   = 1'b0;
        key_value = 4'h0;
        key_valid = 1'b0;
        cmd_ready = 1'b0;
        m_op = '0; m_cnt = '0; m_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.operand", operand, 16'h0);
        chk("rst.count", digit_count, 3'd0);
        chk("rst.opcode", opcode, 2'd0);
        chk("rst.cmd_valid", cmd_valid, 1'b0);
        chk("rst.clear_pulse", clear_pulse, 1'b0);
        chk("rst.overflow", overflow, 1'b0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Digits accumulate.
        press(4'h1, 20, "d1");
        press(4'h2, 20, "d2");
        press(4'h3, 20, "d3");
        chk("d123.operand", operand, 16'h0123);
        chk("d123.count", digit_count, 3'd3);
        chk("d123.no_cmd", cmd_valid, 1'b0);

        // Overflow then clear.
        press(4'h4, 20, "d4");
        press(4'h5, 20, "d5_ovf");
        chk("ovf.operand", operand, 16'h1234);
        chk("ovf.flag", overflow, 1'b1);
        clr0 = clr_pulses;
        press(4'hE, 20, "clear");
        chk("clear.pulses", clr_pulses, clr0 + 1);
        chk("clear.width", clr_max, 1);
        chk("clear.operand", operand, 16'h0);

        // Command held while ALU stalls.
        press(4'h4, 20, "c4");
        press(4'h2, 20, "c2");
        hs0 = hs_cnt;
        key_value = 4'hA;
        key_valid = 1'b1;
        model_key(4'hA);
        wait_cmd(ok);
        chk("cmd.rise", ok, 1'b1);
        bad = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (cmd_valid !== 1'b1 || operand !== 16'h0042 || opcode !== 2'b00) bad++;
        end
        chk("cmd.held", bad, 0);
        cmd_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("cmd.after_valid", cmd_valid, 1'b0);
        chk("cmd.after_operand", operand, 16'h0);
        chk("cmd.after_count", digit_count, 3'd0);
        chk("cmd.hs", hs_cnt, hs0 + 1);
        cmd_ready = 1'b0;
        key_valid = 1'b0;
        push_exp();
        repeat (20) @(posedge clk);
        #1;
        check_sb("cmd.post");

        // Glitch shorter than the hold time, and value changing mid-debounce.
        key_value = 4'h7;
        key_valid = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        key_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        push_exp();
        check_sb("glitch");
        key_valid = 1'b1;
        key_value = 4'h3;
        repeat (5) @(posedge clk);
        #1;
        key_value = 4'h5;
        repeat (5) @(posedge clk);
        #1;
        key_value = 4'h3;
        repeat (5) @(posedge clk);
        #1;
        key_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        push_exp();
        check_sb("bounce");

`ifdef KEYPAD_AUTOREPEAT_EN
        // Held digit repeats every REPEAT_CYCLES after the first accept.
        key_value = 4'h5;
        key_valid = 1'b1;
        repeat (4) model_key(4'h5);
        push_exp();
        repeat (189) @(posedge clk);
        #1;
        key_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_sb("repeat5");
        chk("repeat5.operand", operand, 16'h5555);
        press(4'hE, 20, "repeat.clear");
`else
        // Long hold acts once.
        press(4'h9, 500, "hold9");
        chk("hold9.count", digit_count, 3'd1);
        press(4'hE, 20, "hold.clear");
`endif

        // Backspace down to and past empty.
        press(4'h7, 20, "b7");
        press(4'h8, 20, "b8");
        chk("bsp0.operand", operand, 16'h0078);
        press(4'hF, 20, "bsp1");
        chk("bsp1.operand", operand, 16'h0007);
        chk("bsp1.count", digit_count, 3'd1);
        press(4'hF, 20, "bsp2");
        chk("bsp2.count", digit_count, 3'd0);
        press(4'hF, 20, "bsp3");
        chk("bsp3.operand", operand, 16'h0000);
        chk("bsp3.count", digit_count, 3'd0);

        // EQ with no digits, ALU ready: issues zero operand.
        hs0 = hs_cnt;
        cmd_ready = 1'b1;
        press(4'hD, 20, "eq0");
        chk("eq0.hs", hs_cnt, hs0 + 1);

        // Long-held operator issues once.
        press(4'h3, 20, "op3");
        hs0 = hs_cnt;
        press(4'hB, 189, "sub_hold");
        chk("sub_hold.hs", hs_cnt, hs0 + 1);
        cmd_ready = 1'b0;

        // Reset while a command is pending drops it.
        press(4'h6, 20, "r6");
        key_value = 4'hA;
        key_valid = 1'b1;
        wait_cmd(ok);
        chk("rst_issue.rise", ok, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_issue.cmd_valid", cmd_valid, 1'b0);
        chk("rst_issue.operand", operand, 16'h0);
        key_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_op = '0; m_cnt = '0; m_ovf = 1'b0;
        @(posedge clk);
        #1;
        press(4'h3, 20, "post_rst");

        chk("end.cmd_q_empty", cmd_q.size(), 0);
        chk("end.exp_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
